// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the I and D cache ports of NCORES cores.
// Data requests beat instruction requests; cores within a class are served round-robin.
module mem_arbiter #(
    parameter int NCORES = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NCORES-1:0]        iREN,
    input  logic [NCORES*ADDR_W-1:0] iaddr,
    output logic [NCORES-1:0]        iwait,
    output logic [NCORES*ADDR_W-1:0] iload,
    input  logic [NCORES-1:0]        dREN,
    input  logic [NCORES-1:0]        dWEN,
    input  logic [NCORES*ADDR_W-1:0] daddr,
    input  logic [NCORES*ADDR_W-1:0] dstore,
    output logic [NCORES-1:0]        dwait,
    output logic [NCORES*ADDR_W-1:0] dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [ADDR_W-1:0]        ramstore,
    input  logic [ADDR_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     busy
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef logic [ADDR_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef enum logic [1:0] {IDLE, XFER, RETRY} state_t;

    state_t            state;
    idx_t              rr_d, rr_i, gnt_core, d_win, i_win;
    logic              gnt_d, gnt_wr;
    logic [NCORES-1:0] dreq;
    logic              gnt_active, complete;
    word_t             d_sel_addr, d_sel_store, i_sel_addr;
    logic              d_sel_wr;

    function automatic idx_t next_idx(input idx_t k);
        if (int'(k) == NCORES - 1) return '0;
        return k + idx_t'(1);
    endfunction

    // First requester at or after rr, wrapping; scanning backwards lets the nearest one win.
    function automatic idx_t pick(input logic [NCORES-1:0] req, input idx_t rr);
        idx_t win, cand;
        win = rr;
        for (int off = NCORES - 1; off >= 0; off--) begin
            cand = idx_t'((int'(rr) + off) % NCORES);
            if (req[cand]) win = cand;
        end
        return win;
    endfunction

    assign dreq       = dREN | dWEN;
    assign gnt_active = gnt_d ? dreq[gnt_core] : iREN[gnt_core];
    assign complete   = (state == XFER) && gnt_active && (ramstate == RAM_ACCESS);
    assign busy       = (state != IDLE);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        d_win       = pick(dreq, rr_d);
        i_win       = pick(iREN, rr_i);
        d_sel_addr  = '0;
        d_sel_store = '0;
        d_sel_wr    = 1'b0;
        i_sel_addr  = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (d_win == idx_t'(k)) begin
                d_sel_addr  = daddr[k*ADDR_W +: ADDR_W];
                d_sel_store = dstore[k*ADDR_W +: ADDR_W];
                d_sel_wr    = dWEN[k];
            end
            if (i_win == idx_t'(k)) i_sel_addr = iaddr[k*ADDR_W +: ADDR_W];
        end
    end

    // Waits are released and load data steered only on the completion cycle.
    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (complete && gnt_core == idx_t'(k)) begin
                if (gnt_d) begin
                    dwait[k] = 1'b0;
                    if (!gnt_wr) dload[k*ADDR_W +: ADDR_W] = ramload;
                end else begin
                    iwait[k] = 1'b0;
                    iload[k*ADDR_W +: ADDR_W] = ramload;
                end
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            rr_d     <= '0;
            rr_i     <= '0;
            gnt_core <= '0;
            gnt_d    <= 1'b0;
            gnt_wr   <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dreq) begin
                        gnt_core <= d_win;
                        gnt_d    <= 1'b1;
                        gnt_wr   <= d_sel_wr;
                        ramaddr  <= d_sel_addr;
                        ramstore <= d_sel_store;
                        ramREN   <= ~d_sel_wr;
                        ramWEN   <= d_sel_wr;
                        state    <= XFER;
                    end else if (|iREN) begin
                        gnt_core <= i_win;
                        gnt_d    <= 1'b0;
                        gnt_wr   <= 1'b0;
                        ramaddr  <= i_sel_addr;
                        ramstore <= '0;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!gnt_active) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= IDLE;
                    end else if (ramstate == RAM_ACCESS) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= IDLE;
                        if (gnt_d) rr_d <= next_idx(gnt_core);
                        else       rr_i <= next_idx(gnt_core);
                    end else if (ramstate == RAM_ERROR) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= RETRY;
                    end
                end
                RETRY: begin
                    if (!gnt_active) begin
                        state <= IDLE;
                    end else begin
                        ramREN <= ~gnt_wr;
                        ramWEN <= gnt_wr;
                        state  <= XFER;
                    end
                end
                default: begin
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner-case sequences against a small RAM model;
// every wait release is matched against a queue of expected completions.
module tb_mem_arbiter;

    localparam int NC = 2;

    typedef logic [127:0] val_t;
    typedef struct {
        logic        is_d;
        int          core;
        logic        wr;
        logic [31:0] load;
    } sb_t;
    typedef struct {
        logic        is_d;
        int          core;
        logic        wr;
        logic        both;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        int          nbusy;
        logic        err;
        int          lat;
        logic        exp_wen;
    } vec_t;

    logic             CLK, nRST;
    logic [NC-1:0]    iREN, dREN, dWEN, iwait, dwait;
    logic [NC*32-1:0] iaddr, daddr, dstore, iload, dload;
    logic             ramREN, ramWEN, busy;
    logic [31:0]      ramaddr, ramstore, ramload, rd_value;
    logic [1:0]       ramstate;

    int   nchk = 0, nerr = 0;
    int   busy_left, busy_cfg, rel_core, nrel;
    logic err_arm, ram_hash, auto_drop, rel_valid, rel_is_d, done, en;
    sb_t  sb[$];
    vec_t vecs[6];
    vec_t v;
    int   done_cyc[4];

    mem_arbiter #(.NCORES(NC), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .busy(busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic bit_of(input logic [NC-1:0] vec, input int k);
        return |(vec & (NC'(1) << k));
    endfunction

    task automatic check(input string name, input val_t act, input val_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Mid-cycle: RAM model responds to the registered command, then releases are scored.
    task automatic sample();
        int   n, rc;
        logic rd;
        sb_t  e;
        logic [NC*32-1:0] exp_i, exp_d;
        #1;
        if (ramREN || ramWEN) begin
            if (err_arm) begin
                ramstate = 2'd3;
                err_arm  = 1'b0;
            end else if (busy_left > 0) begin
                ramstate = 2'd1;
                busy_left--;
            end else begin
                ramstate = 2'd2;
            end
        end else begin
            ramstate  = 2'd0;
            busy_left = busy_cfg;
        end
        ramload = ram_hash ? ram_word(ramaddr) : rd_value;
        #1;
        n = 0; rc = 0; rd = 1'b0; rel_valid = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (!bit_of(iwait, k)) begin n++; rd = 1'b0; rc = k; end
            if (!bit_of(dwait, k)) begin n++; rd = 1'b1; rc = k; end
        end
        if (n == 0) begin
            check("loads_idle", {iload, dload}, '0);
        end else if (n > 1) begin
            check("single_release", n, 1);
        end else if (sb.size() == 0) begin
            check("unexpected_release", n, 0);
        end else begin
            e = sb.pop_front();
            check("release_port", {rd, 8'(rc)}, {e.is_d, 8'(e.core)});
            exp_i = '0;
            exp_d = '0;
            if (!e.wr) begin
                if (e.is_d) exp_d[e.core*32 +: 32] = e.load;
                else        exp_i[e.core*32 +: 32] = e.load;
            end
            check("load_bus", {iload, dload}, {exp_i, exp_d});
            rel_valid = 1'b1;
            rel_is_d  = rd;
            rel_core  = rc;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (auto_drop && rel_valid) begin
            if (rel_is_d) begin
                dREN &= ~(NC'(1) << rel_core);
                dWEN &= ~(NC'(1) << rel_core);
            end else begin
                iREN &= ~(NC'(1) << rel_core);
            end
        end
        rel_valid = 1'b0;
    endtask

    task automatic run_until_empty(input string name, input int budget);
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            sample();
            tick();
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        rel_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_vec(input vec_t t);
        if (t.is_d) begin
            daddr[t.core*32 +: 32]  = t.addr;
            dstore[t.core*32 +: 32] = t.store;
            if (t.wr)               dWEN |= NC'(1) << t.core;
            if (!t.wr || t.both)    dREN |= NC'(1) << t.core;
        end else begin
            iaddr[t.core*32 +: 32] = t.addr;
            iREN |= NC'(1) << t.core;
        end
    endtask

    initial begin
        //           is_d  core wr    both  addr          store         rdata         nbusy err   lat wen
        vecs[0] = '{1'b0, 0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 1'b0, 2, 1'b0};
        vecs[1] = '{1'b1, 1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0,        3, 1'b0, 4, 1'b1};
        vecs[2] = '{1'b1, 0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 1, 1'b0};
        vecs[3] = '{1'b0, 1, 1'b0, 1'b0, 32'h0000_0300, 32'h0,        32'h0BAD_F00D, 1, 1'b1, 4, 1'b0};
        vecs[4] = '{1'b1, 0, 1'b1, 1'b1, 32'h0000_0060, 32'hA5A5_5A5A, 32'h0,        0, 1'b0, 1, 1'b1};
        vecs[5] = '{1'b1, 0, 1'b1, 1'b0, 32'h0000_0080, 32'h0F0F_1234, 32'h0,        0, 1'b1, 3, 1'b1};

        ramstate = 2'd0; ramload = '0; rd_value = '0;
        busy_cfg = 1; busy_left = 1; err_arm = 1'b0; ram_hash = 1'b0; auto_drop = 1'b1;
        do_reset();

        sample();
        check("rst_ram_en", {ramREN, ramWEN}, '0);
        check("rst_ramaddr", ramaddr, '0);
        check("rst_ramstore", ramstore, '0);
        check("rst_busy", busy, '0);
        check("rst_waits", {iwait, dwait}, {(2*NC){1'b1}});
        tick();

        // Single isolated transfers from the table.
        for (int vi = 0; vi < 6; vi++) begin
            v = vecs[vi];
            rd_value = v.rdata; busy_cfg = v.nbusy; err_arm = v.err;
            ram_hash = 1'b0; auto_drop = 1'b1;
            drive_vec(v);
            sb.push_back('{v.is_d, v.core, v.wr, v.wr ? 32'h0 : v.rdata});
            done = 1'b0;
            for (int c = 0; c <= 12 && !done; c++) begin
                sample();
                if (c == 0) begin
                    check("grant_cycle_idle", {busy, ramREN, ramWEN}, '0);
                end else begin
                    en = !(v.err && c == 2);
                    check("ram_ren", ramREN, en & ~v.exp_wen);
                    check("ram_wen", ramWEN, en & v.exp_wen);
                    check("ram_addr", ramaddr, v.addr);
                    if (v.exp_wen) check("ram_store", ramstore, v.store);
                    check("busy_xfer", busy, 1'b1);
                    if (sb.size() == 0) begin
                        done = 1'b1;
                        check("latency", c, v.lat);
                    end
                end
                tick();
            end
            if (!done) begin
                check("vec_timeout", sb.size(), 0);
                sb.delete();
                iREN = '0; dREN = '0; dWEN = '0;
            end
            sample();
            check("back_idle", {busy, ramREN, ramWEN}, '0);
            tick();
        end

        // D beats I on a simultaneous request.
        do_reset();
        ram_hash = 1'b1; busy_cfg = 1; auto_drop = 1'b1;
        iREN = 2'b01; iaddr[31:0] = 32'h500;
        dREN = 2'b10; daddr[63:32] = 32'h200;
        sb.push_back('{1'b1, 1, 1'b0, ram_word(32'h200)});
        sb.push_back('{1'b0, 0, 1'b0, ram_word(32'h500)});
        sample(); tick();
        sample();
        check("dprio_first_addr", ramaddr, 32'h200);
        check("dprio_first_ren", ramREN, 1'b1);
        tick();
        run_until_empty("dprio_drain", 20);

        // Round-robin with both D ports requesting continuously.
        do_reset();
        ram_hash = 1'b1; busy_cfg = 0; auto_drop = 1'b0;
        daddr = {32'h20, 32'h10};
        dREN = 2'b11;
        sb.push_back('{1'b1, 0, 1'b0, ram_word(32'h10)});
        sb.push_back('{1'b1, 1, 1'b0, ram_word(32'h20)});
        sb.push_back('{1'b1, 0, 1'b0, ram_word(32'h10)});
        sb.push_back('{1'b1, 1, 1'b0, ram_word(32'h20)});
        nrel = 0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            sample();
            if (rel_valid && nrel < 4) begin
                done_cyc[nrel] = c;
                nrel++;
            end
            tick();
            if (sb.size() == 0) dREN = '0;
        end
        dREN = '0;
        check("rr_count", nrel, 4);
        if (nrel == 4) begin
            check("rr_first_cycle", done_cyc[0], 1);
            check("rr_gap_core0", done_cyc[2] - done_cyc[0], 4);
            check("rr_gap_core1", done_cyc[3] - done_cyc[1], 4);
        end
        sb.delete();
        sample(); tick();

        // Abort: requester drops during BUSY; pointer must stay on core0.
        do_reset();
        ram_hash = 1'b1; busy_cfg = 5; auto_drop = 1'b1;
        dREN = 2'b01; daddr[31:0] = 32'h80;
        sample(); tick();
        sample();
        check("abort_ren", ramREN, 1'b1);
        tick();
        sample(); tick();
        dREN = '0;
        sample(); tick();
        sample();
        check("abort_idle", {busy, ramREN, ramWEN}, '0);
        tick();
        busy_cfg = 0;
        daddr = {32'h90, 32'h80};
        dREN = 2'b11;
        sb.push_back('{1'b1, 0, 1'b0, ram_word(32'h80)});
        sb.push_back('{1'b1, 1, 1'b0, ram_word(32'h90)});
        sample(); tick();
        sample();
        check("rr_kept_addr", ramaddr, 32'h80);
        tick();
        run_until_empty("abort_drain", 20);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        ram_hash = 1'b1; busy_cfg = 5; auto_drop = 1'b1;
        iREN = 2'b10; iaddr[63:32] = 32'h700;
        sample(); tick();
        sample();
        check("midrst_ren_before", ramREN, 1'b1);
        #1 nRST = 1'b0;
        #1;
        check("midrst_ram_en", {ramREN, ramWEN}, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ramaddr", ramaddr, '0);
        check("midrst_waits", {iwait, dwait}, {(2*NC){1'b1}});
        iREN = '0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        tick();
        sample();
        check("midrst_idle", {busy, ramREN, ramWEN}, '0);
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
